uart_controller: RTL
====================

# uart_controller

Memory-mapped UART peripheral with runtime-programmable baud divisor, buffered TX and RX paths, sticky error flags, and a level interrupt. Sits on the core's simple read/write data bus as the next-generation console/serial device. Integrates its own TX/RX bit engines and FIFOs; received data is readable through the bus.

## Interface
- CLOCK_FREQ, 25000000, system clock in Hz
- DEFAULT_BAUD, 9600, baud used to compute the divisor reset value (CLOCK_FREQ/DEFAULT_BAUD)
- DATA_BITS, 8, payload bits per frame, legal 5..8
- FIFO_DEPTH, 8, entries per FIFO, power of two ≥2
- BASE_ADDRESS, 32'h00001000, byte address of register offset 0x0
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- rx  input  1  serial input, asynchronous
- tx  output  1  serial output, idle high
- read  input  1  bus read strobe
- write  input  1  bus write strobe
- address  input  32  byte address
- write_data  input  32  write data
- read_data  output  32  read data, combinational
- irq  output  1  registered level interrupt

## Operation
- Register map (offset from BASE_ADDRESS); other addresses: reads 0, writes ignored:
  - 0x0 DATA: write pushes write_data[DATA_BITS-1:0] to TX FIFO; if full, dropped and TXOVF set. Read returns RX FIFO head zero-extended and pops; if empty, returns 0, no pop.
  - 0x4 STATUS: [0] rx_not_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] tx_busy, [5] RXOVR, [6] FRAMEERR, [7] PARERR, [8] TXOVF. Bits 5–8 sticky; write 1 clears.
  - 0x8 CTRL (R/W): [15:0] divisor (clocks/bit), [16] tx_en, [17] rx_en, [18] rx_irq_en, [19] tx_irq_en.
- Divisor values <4 are treated as 4. New divisor applies at next frame start per engine.
- TX FSM: IDLE→START→DATA→(PARITY)→STOP→IDLE. Leaves IDLE when tx_en=1 and FIFO non-empty (pop on that edge). LSB first, one stop bit. tx_en cleared mid-frame: frame completes, no new start.
- RX: two-flop synchroniser. FSM IDLE→START→DATA→(PARITY)→STOP. Falling edge in IDLE with rx_en=1 enters START; sample at divisor/2; if high, return IDLE (glitch). Data/parity/stop sampled every divisor cycles thereafter. Stop=0: FRAMEERR set, byte discarded. Parity mismatch: PARERR set, byte discarded. Good byte with RX FIFO full: RXOVR set, byte dropped.
- irq = (rx_irq_en & rx_not_empty) | (tx_irq_en & tx_empty), registered one cycle.

## Timing
- Reset values: tx=1, read_data=0 when read=0, irq=0, FIFOs empty, sticky flags 0, divisor=CLOCK_FREQ/DEFAULT_BAUD, tx_en=1, rx_en=1, irq enables 0.
- Reset mid-frame: tx forced to 1 next edge, both FSMs to IDLE, FIFO contents lost.
- TX latency: write at edge N with idle engine → pop at N+1 → tx low from N+2. Frame length (2+DATA_BITS+P)·divisor cycles, P=1 if parity enabled.
- RX: byte visible (rx_not_empty=1) one cycle after the mid-stop-bit sample.
- Full/empty judged on pre-edge state: write to full TX FIFO dropped even if engine pops same cycle; read of empty RX FIFO returns 0 even if a byte is pushed same cycle (byte retained).
- Pointer wrap at FIFO_DEPTH; full/empty via extra pointer bit.

## Configuration
- UART_PARITY_EN defined: CTRL[20] parity_en, CTRL[21] odd (0=even); PARITY state active when parity_en=1; PARERR functional.
- Not defined: no PARITY states, CTRL[21:20] read 0 and ignore writes, PARERR always 0.

## Test plan
- Reset, CTRL=divisor 8, write 0x55 to DATA → tx shows start,1010 1010 LSB-first,stop, 80 cycles total; tx_empty=1 after.
- Write 9 bytes to full-depth-8 FIFO with tx_en=0 → 9th dropped, STATUS[8]=1, tx_full=1; write 0x100 to STATUS clears it.
- Drive rx with 0xA3 at divisor 8 → rx_not_empty=1, DATA read returns 0x000000A3, then STATUS[0]=0; read empty returns 0.
- Drive 9 frames without reading → RXOVR=1, first 8 bytes read back in order.
- Drive frame with stop=0 → FRAMEERR=1, FIFO stays empty; 2-cycle low glitch on rx → no frame, no error.
- With UART_PARITY_EN, even parity, send 0x07 with parity bit 0 → PARERR=1, byte discarded; correct parity 1 → byte accepted; rx_irq_en=1 → irq high one cycle after rx_not_empty.

Source files
------------

// File: rtl/uart_controller.sv
// Memory-mapped UART: programmable divisor, TX/RX FIFOs, sticky error flags, level irq.
// Optional parity support is compiled in when UART_PARITY_EN is defined.
module uart_controller #(
  parameter int          CLOCK_FREQ   = 25000000,
  parameter int          DEFAULT_BAUD = 9600,
  parameter int          DATA_BITS    = 8,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDRESS = 32'h00001000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        irq
);
  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_RESET   = 16'(CLOCK_FREQ / DEFAULT_BAUD);
  localparam logic [31:0] ADDR_DATA   = BASE_ADDRESS;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDRESS + 32'd4;
  localparam logic [31:0] ADDR_CTRL   = BASE_ADDRESS + 32'd8;
  localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [15:0] divisor_reg, eff_div;
  logic        tx_en_reg, rx_en_reg, rx_irq_en_reg, tx_irq_en_reg;
  logic        parity_en, parity_odd;
  logic        rxovr_reg, frame_err_reg, par_err_reg, txovf_reg;
  logic        irq_reg;

  logic sel_data, sel_status, sel_ctrl;
  logic wr_data, rd_data, wr_status, wr_ctrl;
  logic unused_bits;

  assign sel_data    = (address == ADDR_DATA);
  assign sel_status  = (address == ADDR_STATUS);
  assign sel_ctrl    = (address == ADDR_CTRL);
  assign wr_data     = write & sel_data;
  assign rd_data     = read & sel_data;
  assign wr_status   = write & sel_status;
  assign wr_ctrl     = write & sel_ctrl;
  assign unused_bits = ^write_data;
  assign eff_div     = (divisor_reg < 16'd4) ? 16'd4 : divisor_reg;

  // ---------------- FIFOs (extra pointer bit distinguishes full from empty)
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [DATA_BITS-1:0] tx_head, rx_head;

  assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
  assign tx_full  = (tx_wr_ptr_reg[AW] != tx_rd_ptr_reg[AW]) &&
                    (tx_wr_ptr_reg[AW-1:0] == tx_rd_ptr_reg[AW-1:0]);
  assign rx_empty = (rx_wr_ptr_reg == rx_rd_ptr_reg);
  assign rx_full  = (rx_wr_ptr_reg[AW] != rx_rd_ptr_reg[AW]) &&
                    (rx_wr_ptr_reg[AW-1:0] == rx_rd_ptr_reg[AW-1:0]);
  assign tx_push  = wr_data & ~tx_full;
  assign rx_pop   = rd_data & ~rx_empty;
  assign tx_head  = tx_mem[tx_rd_ptr_reg[AW-1:0]];
  assign rx_head  = rx_mem[rx_rd_ptr_reg[AW-1:0]];

  logic [DATA_BITS-1:0] rx_shift_reg;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg[AW-1:0]] <= write_data[DATA_BITS-1:0];
    if (rx_push) rx_mem[rx_wr_ptr_reg[AW-1:0]] <= rx_shift_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
    end
  end

  // ---------------- control register
  always_ff @(posedge clk) begin
    if (reset) begin
      divisor_reg   <= DIV_RESET;
      tx_en_reg     <= 1'b1;
      rx_en_reg     <= 1'b1;
      rx_irq_en_reg <= 1'b0;
      tx_irq_en_reg <= 1'b0;
    end else if (wr_ctrl) begin
      divisor_reg   <= write_data[15:0];
      tx_en_reg     <= write_data[16];
      rx_en_reg     <= write_data[17];
      rx_irq_en_reg <= write_data[18];
      tx_irq_en_reg <= write_data[19];
    end
  end

`ifdef UART_PARITY_EN
  logic parity_en_reg, parity_odd_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_en_reg  <= 1'b0;
      parity_odd_reg <= 1'b0;
    end else if (wr_ctrl) begin
      parity_en_reg  <= write_data[20];
      parity_odd_reg <= write_data[21];
    end
  end
  assign parity_en  = parity_en_reg;
  assign parity_odd = parity_odd_reg;
`else
  assign parity_en  = 1'b0;
  assign parity_odd = 1'b0;
`endif

  // ---------------- TX engine; divisor and parity mode latched at frame start
  state_t               tx_state_reg, tx_state_next;
  logic [15:0]          tx_cnt_reg, tx_cnt_next, tx_div_reg, tx_div_next;
  logic [2:0]           tx_bit_reg, tx_bit_next;
  logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic                 tx_par_reg, tx_par_next, tx_par_en_reg, tx_par_en_next;
  logic                 tx_line_reg, tx_line_next, tx_tick;

  assign tx_tick = (tx_cnt_reg == tx_div_reg - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_reg  <= S_IDLE;
      tx_cnt_reg    <= '0;
      tx_div_reg    <= 16'd4;
      tx_bit_reg    <= '0;
      tx_shift_reg  <= '0;
      tx_par_reg    <= 1'b0;
      tx_par_en_reg <= 1'b0;
      tx_line_reg   <= 1'b1;
    end else begin
      tx_state_reg  <= tx_state_next;
      tx_cnt_reg    <= tx_cnt_next;
      tx_div_reg    <= tx_div_next;
      tx_bit_reg    <= tx_bit_next;
      tx_shift_reg  <= tx_shift_next;
      tx_par_reg    <= tx_par_next;
      tx_par_en_reg <= tx_par_en_next;
      tx_line_reg   <= tx_line_next;
    end
  end

  always_comb begin
    tx_state_next  = tx_state_reg;
    tx_cnt_next    = tx_tick ? 16'd0 : tx_cnt_reg + 16'd1;
    tx_div_next    = tx_div_reg;
    tx_bit_next    = tx_bit_reg;
    tx_shift_next  = tx_shift_reg;
    tx_par_next    = tx_par_reg;
    tx_par_en_next = tx_par_en_reg;
    tx_line_next   = 1'b1;
    tx_pop         = 1'b0;
    unique case (tx_state_reg)
      S_IDLE: begin
        tx_cnt_next = '0;
        if (tx_en_reg && !tx_empty) begin
          tx_pop         = 1'b1;
          tx_state_next  = S_START;
          tx_shift_next  = tx_head;
          tx_div_next    = eff_div;
          tx_par_en_next = parity_en;
          tx_par_next    = (^tx_head) ^ parity_odd;
        end
      end
      S_START: begin
        tx_line_next = 1'b0;
        if (tx_tick) begin
          tx_state_next = S_DATA;
          tx_bit_next   = '0;
        end
      end
      S_DATA: begin
        tx_line_next = tx_shift_reg[0];
        if (tx_tick) begin
          tx_shift_next = tx_shift_reg >> 1;
          tx_bit_next   = tx_bit_reg + 3'd1;
          if (tx_bit_reg == LAST_BIT) tx_state_next = tx_par_en_reg ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        tx_line_next = tx_par_reg;
        if (tx_tick) tx_state_next = S_STOP;
      end
      S_STOP: begin
        if (tx_tick) tx_state_next = S_IDLE;
      end
      default: tx_state_next = S_IDLE;
    endcase
  end

  assign tx = tx_line_reg;

  // ---------------- RX engine
  state_t               rx_state_reg, rx_state_next;
  logic [15:0]          rx_cnt_reg, rx_cnt_next, rx_div_reg, rx_div_next;
  logic [2:0]           rx_bit_reg, rx_bit_next;
  logic [DATA_BITS-1:0] rx_shift_next;
  logic                 rx_par_en_reg, rx_par_en_next, rx_odd_reg, rx_odd_next;
  logic                 rx_par_bit_reg, rx_par_bit_next;
  logic                 rx_sync1_reg, rx_sync2_reg, rx_prev_reg, rx_tick;
  logic                 frame_err_set, par_err_set, rxovr_set;

  assign rx_tick = (rx_cnt_reg == rx_div_reg - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync1_reg   <= 1'b1;
      rx_sync2_reg   <= 1'b1;
      rx_prev_reg    <= 1'b1;
      rx_state_reg   <= S_IDLE;
      rx_cnt_reg     <= '0;
      rx_div_reg     <= 16'd4;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_par_en_reg  <= 1'b0;
      rx_odd_reg     <= 1'b0;
      rx_par_bit_reg <= 1'b0;
    end else begin
      rx_sync1_reg   <= rx;
      rx_sync2_reg   <= rx_sync1_reg;
      rx_prev_reg    <= rx_sync2_reg;
      rx_state_reg   <= rx_state_next;
      rx_cnt_reg     <= rx_cnt_next;
      rx_div_reg     <= rx_div_next;
      rx_bit_reg     <= rx_bit_next;
      rx_shift_reg   <= rx_shift_next;
      rx_par_en_reg  <= rx_par_en_next;
      rx_odd_reg     <= rx_odd_next;
      rx_par_bit_reg <= rx_par_bit_next;
    end
  end

  always_comb begin
    rx_state_next   = rx_state_reg;
    rx_cnt_next     = rx_tick ? 16'd0 : rx_cnt_reg + 16'd1;
    rx_div_next     = rx_div_reg;
    rx_bit_next     = rx_bit_reg;
    rx_shift_next   = rx_shift_reg;
    rx_par_en_next  = rx_par_en_reg;
    rx_odd_next     = rx_odd_reg;
    rx_par_bit_next = rx_par_bit_reg;
    rx_push         = 1'b0;
    frame_err_set   = 1'b0;
    par_err_set     = 1'b0;
    rxovr_set       = 1'b0;
    unique case (rx_state_reg)
      S_IDLE: begin
        rx_cnt_next = '0;
        if (rx_en_reg && rx_prev_reg && !rx_sync2_reg) begin
          rx_state_next  = S_START;
          rx_div_next    = eff_div;
          rx_par_en_next = parity_en;
          rx_odd_next    = parity_odd;
        end
      end
      S_START: begin
        // Mid-start-bit check rejects short glitches.
        if (rx_cnt_reg == (rx_div_reg >> 1) - 16'd1) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_sync2_reg ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_shift_next = {rx_sync2_reg, rx_shift_reg[DATA_BITS-1:1]};
          rx_bit_next   = rx_bit_reg + 3'd1;
          if (rx_bit_reg == LAST_BIT) rx_state_next = rx_par_en_reg ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (rx_tick) begin
          rx_par_bit_next = rx_sync2_reg;
          rx_state_next   = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_tick) begin
          rx_state_next = S_IDLE;
          if (!rx_sync2_reg) frame_err_set = 1'b1;
          else if (rx_par_en_reg && (rx_par_bit_reg != ((^rx_shift_reg) ^ rx_odd_reg)))
            par_err_set = 1'b1;
          else if (rx_full) rxovr_set = 1'b1;
          else rx_push = 1'b1;
        end
      end
      default: rx_state_next = S_IDLE;
    endcase
  end

  // ---------------- sticky flags (a new event wins over a same-cycle clear), irq
  always_ff @(posedge clk) begin
    if (reset) begin
      rxovr_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      par_err_reg   <= 1'b0;
      txovf_reg     <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      rxovr_reg     <= rxovr_set     | (rxovr_reg     & ~(wr_status & write_data[5]));
      frame_err_reg <= frame_err_set | (frame_err_reg & ~(wr_status & write_data[6]));
      par_err_reg   <= par_err_set   | (par_err_reg   & ~(wr_status & write_data[7]));
      txovf_reg     <= (wr_data & tx_full) | (txovf_reg & ~(wr_status & write_data[8]));
      irq_reg       <= (rx_irq_en_reg & ~rx_empty) | (tx_irq_en_reg & tx_empty);
    end
  end

  assign irq = irq_reg;

  always_comb begin
    read_data = '0;
    if (read) begin
      if (sel_data && !rx_empty)
        read_data = {{(32-DATA_BITS){1'b0}}, rx_head};
      else if (sel_status)
        read_data = {23'd0, txovf_reg, par_err_reg, frame_err_reg, rxovr_reg,
                     (tx_state_reg != S_IDLE), tx_full, tx_empty, rx_full, ~rx_empty};
      else if (sel_ctrl)
        read_data = {10'd0, parity_odd, parity_en, tx_irq_en_reg, rx_irq_en_reg,
                     rx_en_reg, tx_en_reg, divisor_reg};
    end
  end
endmodule
